// File: rtl/mips_muldiv_ctrl.sv
// mips_muldiv_ctrl: MIPS HI/LO multiply/divide unit controller.
//   Iterative shift-add multiply and restoring divide, one bit per cycle
//   (32 cycles), plus MTHI/MTLO writes and MFHI/MFLO reads with stall.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   op_valid/op_ready     operation handshake; op_code/src_a/src_b captured on accept
//   rd_req/rd_sel         HI/LO read request (rd_sel 1 = HI, 0 = LO)
//   rd_data               combinational HI/LO read data
//   stall                 read requested while an operation is in flight
//   busy                  MUL/DIV/FIX/DZ in progress
//   div_zero              one-cycle pulse on divide by zero
// Build option: define MIPS_MULDIV_SIGNED_EN to make MULT/DIV signed
//   (adds a FIX cycle that applies result signs); otherwise they run unsigned.
module mips_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             rd_req,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             stall,
    output logic             busy,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_DIVU  = 3'b001;
    localparam logic [2:0] OP_MULT  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        DZ   = 3'd3
`ifdef MIPS_MULDIV_SIGNED_EN
        , FIX = 3'd4
`endif
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   hi, lo, opnd;
    logic [2*WIDTH-1:0] acc, mul_next, div_next;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [CW-1:0]      cnt;
    logic               accept, is_mul, is_div, last_step, sgn;
    logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef MIPS_MULDIV_SIGNED_EN
    logic op_sgn, neg_q, neg_r, fix_div;
`else
    assign sgn = 1'b0;
`endif

    // Operand decode and magnitude conversion
    always_comb begin
        accept    = op_valid && (state == IDLE);
        is_mul    = (op_code == OP_MULTU) || (op_code == OP_MULT);
        is_div    = (op_code == OP_DIVU) || (op_code == OP_DIV);
        last_step = (cnt == LAST);
`ifdef MIPS_MULDIV_SIGNED_EN
        op_sgn = op_code[1] && (is_mul || is_div);
        a_mag  = (op_sgn && src_a[WIDTH-1]) ? -src_a : src_a;
        b_mag  = (op_sgn && src_b[WIDTH-1]) ? -src_b : src_b;
`else
        a_mag  = src_a;
        b_mag  = src_b;
`endif
    end

    // acc is shared: {partial product, multiplier} while multiplying,
    // {partial remainder, dividend/quotient} while dividing.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mul)      state_nxt = MUL;
                    else if (is_div) state_nxt = (src_b == '0) ? DZ : DIV;
                end
            end
            MUL, DIV: begin
                if (last_step) begin
`ifdef MIPS_MULDIV_SIGNED_EN
                    state_nxt = sgn ? FIX : IDLE;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef MIPS_MULDIV_SIGNED_EN
            FIX:     state_nxt = IDLE;
`endif
            DZ:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        op_ready = (state == IDLE);
        busy     = (state != IDLE);
        div_zero = (state == DZ);
        stall    = rd_req && busy;
        rd_data  = rd_sel ? hi : lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            acc  <= '0;
            opnd <= '0;
            cnt  <= '0;
`ifdef MIPS_MULDIV_SIGNED_EN
            sgn     <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            fix_div <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        if (op_code == OP_MTHI) begin
                            hi <= src_a;
                        end else if (op_code == OP_MTLO) begin
                            lo <= src_a;
                        end else if (is_mul) begin
                            acc  <= {{WIDTH{1'b0}}, b_mag};
                            opnd <= a_mag;
                        end else if (is_div) begin
                            acc  <= {{WIDTH{1'b0}}, a_mag};
                            opnd <= b_mag;
                        end
`ifdef MIPS_MULDIV_SIGNED_EN
                        sgn     <= op_sgn;
                        fix_div <= is_div;
                        neg_q   <= op_sgn && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        neg_r   <= op_sgn && src_a[WIDTH-1];
`endif
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + CW'(1);
                    if (last_step && !sgn) {hi, lo} <= mul_next;
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt + CW'(1);
                    if (last_step && !sgn) begin
                        hi <= div_next[2*WIDTH-1:WIDTH];
                        lo <= div_next[WIDTH-1:0];
                    end
                end
`ifdef MIPS_MULDIV_SIGNED_EN
                FIX: begin
                    if (fix_div) begin
                        lo <= neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        hi <= neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                    end else begin
                        {hi, lo} <= neg_q ? -acc : acc;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// Self-checking bench for mips_muldiv_ctrl: directed cases with literal
// expectations plus randomized operations, all compared every cycle against
// an arithmetic reference model (result + remaining busy cycles).
module tb_mips_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = '0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        rd_req = 1'b0, rd_sel = 1'b0;
    logic        op_ready, stall, busy, div_zero;
    logic [31:0] rd_data;

    int n_vec = 0;
    int n_err = 0;

    mips_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .src_a(src_a), .src_b(src_b), .rd_req(rd_req),
        .rd_sel(rd_sel), .rd_data(rd_data), .stall(stall), .busy(busy),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;
    int          m_left = 0;
    bit          m_dz = 1'b0;

    task automatic model_accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        p;
        logic signed [63:0] sa64, sb64;
        logic signed [31:0] sa, sb;
        bit                 signed_op;
`ifdef MIPS_MULDIV_SIGNED_EN
        signed_op = op[1];
`else
        signed_op = 1'b0;
`endif
        m_dz = 1'b0;
        case (op)
            3'd0, 3'd2: begin
                if (signed_op) begin
                    sa64 = {{32{a[31]}}, a};
                    sb64 = {{32{b[31]}}, b};
                    p = sa64 * sb64;
                    m_left = 33;
                end else begin
                    p = {32'b0, a} * {32'b0, b};
                    m_left = 32;
                end
                m_rhi = p[63:32];
                m_rlo = p[31:0];
            end
            3'd1, 3'd3: begin
                if (b == 0) begin
                    m_left = 1;
                    m_dz = 1'b1;
                end else if (signed_op) begin
                    m_left = 33;
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        m_rlo = 32'h8000_0000;
                        m_rhi = 32'h0;
                    end else begin
                        sa = a;
                        sb = b;
                        m_rlo = sa / sb;
                        m_rhi = sa % sb;
                    end
                end else begin
                    m_left = 32;
                    m_rlo = a / b;
                    m_rhi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_dz = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && !m_dz) begin
                m_hi = m_rhi;
                m_lo = m_rlo;
            end
        end else if (op_valid) begin
            model_accept(op_code, src_a, src_b);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic exp_busy;
        exp_busy = (m_left != 0);
        check("op_ready", op_ready, !exp_busy);
        check("busy", busy, exp_busy);
        check("stall", stall, rd_req && exp_busy);
        check("div_zero", div_zero, exp_busy && m_dz);
        check("rd_data", rd_data, rd_sel ? m_hi : m_lo);
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit got;
        got = 1'b0;
        @(posedge clk); #2;
        op_code = op; src_a = a; src_b = b; op_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (op_ready) begin got = 1'b1; break; end
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #2;
        op_valid = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
    endtask

    task automatic count_busy(output int nb, output int nz);
        bit done;
        nb = 0; nz = 0; done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin done = 1'b1; break; end
            nb++;
            if (div_zero) nz++;
        end
        if (!done) check("busy_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_busy, input int exp_dz);
        int nb, nz;
        issue(op, a, b);
        count_busy(nb, nz);
        check({name, "_busy"}, nb, exp_busy);
        check({name, "_dz"}, nz, exp_dz);
    endtask

    task automatic read_chk(input string name, input logic sel, input logic [31:0] exp);
        @(posedge clk); #2;
        rd_sel = sel;
        #1;
        check(name, rd_data, exp);
    endtask

    task automatic chk_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
        read_chk({name, "_hi"}, 1'b1, eh);
        read_chk({name, "_lo"}, 1'b0, el);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       rnd_opnd = 32'h0;
            1:       rnd_opnd = 32'hFFFF_FFFF;
            2:       rnd_opnd = 32'h8000_0000;
            3:       rnd_opnd = $urandom_range(0, 20);
            default: rnd_opnd = $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rop;
        int         gap;
        bit         got;

        // reset values
        #1 rst_n = 1'b0; rd_req = 1'b1;
        #1;
        check("rst_op_ready", op_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_div_zero", div_zero, 1'b0);
        check("rst_rd_data", rd_data, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1; rd_req = 1'b0;

        run_op("multu_max", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 0);
        chk_hilo("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

`ifdef MIPS_MULDIV_SIGNED_EN
        run_op("mult_neg", 3'd2, 32'hFFFF_FFFD, 32'd5, 33, 0);
        chk_hilo("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 33, 0);
        chk_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 33, 0);
        chk_hilo("div_ovf", 32'h0, 32'h8000_0000);
`else
        run_op("mult_neg", 3'd2, 32'hFFFF_FFFD, 32'd5, 32, 0);
        chk_hilo("mult_neg", 32'h0000_0004, 32'hFFFF_FFF1);
        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 32, 0);
        chk_hilo("div_neg", 32'h0000_0001, 32'h7FFF_FFFC);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32, 0);
        chk_hilo("div_ovf", 32'h8000_0000, 32'h0);
`endif
        run_op("divu", 3'd1, 32'd100, 32'd7, 32, 0);
        chk_hilo("divu", 32'd2, 32'd14);

        // divide by zero leaves HI/LO untouched
        run_op("mthi", 3'd4, 32'h11, 32'h0, 0, 0);
        run_op("mtlo", 3'd5, 32'h22, 32'h0, 0, 0);
        run_op("divu_zero", 3'd1, 32'd100, 32'd0, 1, 1);
        chk_hilo("divu_zero", 32'h11, 32'h22);
        run_op("reserved", 3'd6, 32'hDEAD_BEEF, 32'h1, 0, 0);
        chk_hilo("reserved", 32'h11, 32'h22);

        // read stall during busy, MTLO held until IDLE
        issue(3'd0, 32'd3, 32'd4);
        rd_req = 1'b1; rd_sel = 1'b0; op_code = 3'd5; src_a = 32'h55; op_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin got = 1'b1; break; end
            check("stall_in_busy", stall, 1'b1);
        end
        if (!got) check("busy_timeout", 32'd0, 32'd1);
        check("stall_after", stall, 1'b0);
        check("lo_after_mul", rd_data, 32'd12);
        @(posedge clk); #2;
        op_valid = 1'b0; rd_req = 1'b0;
        #1 check("lo_after_mtlo", rd_data, 32'h55);

        // reset in the middle of a divide
        issue(3'd1, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_ready", op_ready, 1'b1);
        check("abort_lo", rd_data, 32'h0);
        rd_sel = 1'b1;
        #1 check("abort_hi", rd_data, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1; rd_sel = 1'b0;
        run_op("multu_small", 3'd0, 32'd2, 32'd3, 32, 0);
        read_chk("multu_small_lo", 1'b0, 32'd6);

        // randomized traffic, ops often issued while busy
        for (int k = 0; k < 70; k++) begin
            rop = 3'($urandom_range(0, 7));
            issue(rop, rnd_opnd(), rnd_opnd());
            gap = $urandom_range(0, 38);
            for (int c = 0; c < gap; c++) begin
                @(posedge clk); #2;
                rd_req = 1'($urandom_range(0, 1));
                rd_sel = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 299) == 0) begin
                    rst_n = 1'b0;
                    @(posedge clk); #2;
                    rst_n = 1'b1;
                end
            end
        end

        @(posedge clk); #2;
        rd_req = 1'b0;
        repeat (40) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
